// File: rtl/legv8_control_fsm_if.sv
// Control-word bundle between the LEGv8 multi-cycle control unit and dataPath_core.
// The control unit drives the control word; the datapath returns IR_out and status.
interface legv8_control_fsm_if;
    logic [31:0] IR_out;
    logic [3:0]  status;

    logic        w_reg;
    logic        C0;
    logic        mem_cs;
    logic        mem_write_en;
    logic        IR_load;
    logic        status_load;
    logic        B_Sel;
    logic        PC_sel;
    logic        add_tri_sel;
    logic [1:0]  data_tri_sel;
    logic [1:0]  PC_FS;
    logic [4:0]  FS;
    logic [1:0]  size;
    logic [4:0]  SA;
    logic [4:0]  SB;
    logic [4:0]  DA;
    logic [31:0] k;
    logic [2:0]  state;
    logic        halted;

    // Control unit side
    modport master (
        input  IR_out, status,
        output w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, B_Sel, PC_sel,
               add_tri_sel, data_tri_sel, PC_FS, FS, size, SA, SB, DA, k, state, halted
    );

    // Datapath side
    modport slave (
        output IR_out, status,
        input  w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, B_Sel, PC_sel,
               add_tri_sel, data_tri_sel, PC_FS, FS, size, SA, SB, DA, k, state, halted
    );
endinterface

// File: rtl/legv8_control_fsm.sv
// Multi-cycle Moore control unit for the LEGv8 dataPath_core: fetch, decode and execute
// of ADD, SUB, ADDI, LDUR, STUR, B and CBZ; any other opcode parks the machine in S_HALT.
module legv8_control_fsm (
    input  logic                  clock,
    input  logic                  reset,
    legv8_control_fsm_if.master   ctrl
);
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam int         Z_BIT  = 0;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_BR     = 3'd4,
        S_CBZ1   = 3'd5,
        S_CBZ2   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t state_reg;
    state_t state_next;

    // ------------------------------------------------------------------
    // Instruction field extraction and opcode match
    // ------------------------------------------------------------------
    logic [31:0] ir;
    logic [4:0]  f_rd;
    logic [4:0]  f_rn;
    logic [4:0]  f_rm;
    logic [31:0] imm12_ext;
    logic [31:0] d_ext;
    logic [31:0] br_k;
    logic [31:0] cb_k;

    logic op_add;
    logic op_sub;
    logic op_addi;
    logic op_ldur;
    logic op_stur;
    logic op_b;
    logic op_cbz;

    assign ir        = ctrl.IR_out;
    assign f_rd      = ir[4:0];
    assign f_rn      = ir[9:5];
    assign f_rm      = ir[20:16];
    assign imm12_ext = {20'd0, ir[21:10]};
    assign d_ext     = {{23{ir[20]}}, ir[20:12]};

    // Branch offsets are word-scaled; the -4 undoes the PC+4 already done in S_FETCH.
    assign br_k = {{4{ir[25]}},  ir[25:0], 2'b00} - 32'd4;
    assign cb_k = {{11{ir[23]}}, ir[23:5], 2'b00} - 32'd4;

    assign op_add  = (ir[31:21] == 11'b10001011000);
    assign op_sub  = (ir[31:21] == 11'b11001011000);
    assign op_addi = (ir[31:22] == 10'b1001000100);
    assign op_ldur = (ir[31:21] == 11'b11111000010);
    assign op_stur = (ir[31:21] == 11'b11111000000);
    assign op_b    = (ir[31:26] == 6'b000101);
    assign op_cbz  = (ir[31:24] == 8'b10110100);

    // Only the zero flag steers the sequence; the other flags are ignored here.
    logic unused_status;
    assign unused_status = ^ctrl.status[3:1];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (op_add || op_sub || op_addi) begin
                    state_next = S_EXEC;
                end else if (op_ldur || op_stur) begin
                    state_next = S_MEM;
                end else if (op_b) begin
                    state_next = S_BR;
                end else if (op_cbz) begin
                    state_next = S_CBZ1;
                end else begin
                    state_next = S_HALT;
                end
            end
            S_EXEC:   state_next = S_FETCH;
            S_MEM:    state_next = S_FETCH;
            S_BR:     state_next = S_FETCH;
            S_CBZ1:   state_next = S_CBZ2;
            S_CBZ2:   state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Control word
    // ------------------------------------------------------------------
    logic        w_reg;
    logic        c0;
    logic        mem_cs;
    logic        mem_write_en;
    logic        ir_load;
    logic        status_load;
    logic        b_sel;
    logic        pc_sel;
    logic        add_tri_sel;
    logic [1:0]  data_tri_sel;
    logic [1:0]  pc_fs;
    logic [4:0]  fs;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic [31:0] k;
    logic        halted;

    always_comb begin
        w_reg        = 1'b0;
        c0           = 1'b0;
        mem_cs       = 1'b0;
        mem_write_en = 1'b0;
        ir_load      = 1'b0;
        status_load  = 1'b0;
        b_sel        = 1'b0;
        pc_sel       = 1'b0;
        add_tri_sel  = 1'b1;
        data_tri_sel = 2'd0;
        pc_fs        = 2'b00;
        fs           = FS_ADD;
        sa           = 5'd0;
        sb           = 5'd0;
        da           = 5'd0;
        k            = 32'd0;
        halted       = 1'b0;

        case (state_reg)
            S_FETCH: begin
                add_tri_sel  = 1'b1;
                mem_cs       = 1'b1;
                data_tri_sel = 2'd3;
                ir_load      = 1'b1;
                pc_fs        = 2'b01;
            end
            S_EXEC: begin
                sa           = f_rn;
                sb           = f_rm;
                da           = f_rd;
                w_reg        = 1'b1;
                data_tri_sel = 2'd0;
                if (op_sub) begin
                    fs = FS_SUB;
                    c0 = 1'b1;
                end else if (op_addi) begin
                    b_sel = 1'b1;
                    k     = imm12_ext;
                end
            end
            S_MEM: begin
                // Address is always Rn + sext(D); only the data path differs.
                sa          = f_rn;
                b_sel       = 1'b1;
                k           = d_ext;
                add_tri_sel = 1'b0;
                mem_cs      = 1'b1;
                if (op_stur) begin
                    sb           = f_rd;
                    data_tri_sel = 2'd1;
                    mem_write_en = 1'b1;
                end else begin
                    data_tri_sel = 2'd3;
                    da           = f_rd;
                    w_reg        = 1'b1;
                end
            end
            S_BR: begin
                pc_fs  = 2'b11;
                pc_sel = 1'b1;
                k      = br_k;
            end
            S_CBZ1: begin
                // Pass Rt through the ALU (Rt + 0) just to refresh the zero flag.
                sa          = f_rd;
                b_sel       = 1'b1;
                status_load = 1'b1;
            end
            S_CBZ2: begin
                if (ctrl.status[Z_BIT]) begin
                    pc_fs  = 2'b11;
                    pc_sel = 1'b1;
                    k      = cb_k;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ctrl.w_reg        = w_reg;
    assign ctrl.C0           = c0;
    assign ctrl.mem_cs       = mem_cs;
    assign ctrl.mem_write_en = mem_write_en;
    assign ctrl.IR_load      = ir_load;
    assign ctrl.status_load  = status_load;
    assign ctrl.B_Sel        = b_sel;
    assign ctrl.PC_sel       = pc_sel;
    assign ctrl.add_tri_sel  = add_tri_sel;
    assign ctrl.data_tri_sel = data_tri_sel;
    assign ctrl.PC_FS        = pc_fs;
    assign ctrl.FS           = fs;
    assign ctrl.size         = 2'b11;
    assign ctrl.SA           = sa;
    assign ctrl.SB           = sb;
    assign ctrl.DA           = da;
    assign ctrl.k            = k;
    assign ctrl.state        = state_reg;
    assign ctrl.halted       = halted;
endmodule

// File: tb/tb_legv8_control_fsm.sv
// Bench for legv8_control_fsm: directed vector table, hand-written reset/halt sequences,
// and random instruction streams checked against an instruction-level reference model.
module tb_legv8_control_fsm;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    legv8_control_fsm_if bus ();

    legv8_control_fsm dut (
        .clock (clock),
        .reset (reset),
        .ctrl  (bus.master)
    );

    typedef struct packed {
        logic [2:0]  state;
        logic        halted;
        logic [7:0]  en;       // {w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, B_Sel, PC_sel}
        logic        add_tri;
        logic [1:0]  dts;
        logic [1:0]  pc_fs;
        logic [4:0]  fs;
        logic [1:0]  size;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic [31:0] k;
    } word_t;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        z;
        int          step;
        word_t       exp;
    } vec_t;

    typedef enum int { C_ADD, C_SUB, C_ADDI, C_LDUR, C_STUR, C_B, C_CBZ, C_BAD } cls_t;

    vec_t tv[$];
    int   checks = 0;
    int   passes = 0;

    function automatic word_t observe();
        word_t w;
        w.state   = bus.state;
        w.halted  = bus.halted;
        w.en      = {bus.w_reg, bus.C0, bus.mem_cs, bus.mem_write_en,
                     bus.IR_load, bus.status_load, bus.B_Sel, bus.PC_sel};
        w.add_tri = bus.add_tri_sel;
        w.dts     = bus.data_tri_sel;
        w.pc_fs   = bus.PC_FS;
        w.fs      = bus.FS;
        w.size    = bus.size;
        w.sa      = bus.SA;
        w.sb      = bus.SB;
        w.da      = bus.DA;
        w.k       = bus.k;
        return w;
    endfunction

    function automatic word_t mk(logic [2:0] st, logic [7:0] en, logic at, logic [1:0] dts,
                                 logic [1:0] pcfs, logic [4:0] fs, logic [4:0] sa,
                                 logic [4:0] sb, logic [4:0] da, logic [31:0] k, logic h);
        word_t w;
        w.state = st; w.halted = h; w.en = en; w.add_tri = at; w.dts = dts;
        w.pc_fs = pcfs; w.fs = fs; w.size = 2'b11; w.sa = sa; w.sb = sb; w.da = da; w.k = k;
        return w;
    endfunction

    task automatic check_word(input string name, input word_t act, input word_t exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // ---------------- reference model (instruction-level) ----------------
    function automatic cls_t classify(logic [31:0] ir);
        int unsigned top11 = ir >> 21;
        if (top11 == 11'h458) return C_ADD;
        if (top11 == 11'h658) return C_SUB;
        if ((ir >> 22) == 32'h244) return C_ADDI;
        if (top11 == 11'h7C2) return C_LDUR;
        if (top11 == 11'h7C0) return C_STUR;
        if ((ir >> 26) == 32'h05) return C_B;
        if ((ir >> 24) == 32'hB4) return C_CBZ;
        return C_BAD;
    endfunction

    function automatic int instr_len(cls_t c);
        if (c == C_CBZ) return 4;
        if (c == C_BAD) return 0;
        return 3;
    endfunction

    // Expected control word on cycle 'step' of an instruction (0 = fetch cycle).
    function automatic word_t model(logic [31:0] ir, logic z, int step);
        word_t w;
        cls_t  c   = classify(ir);
        int    rd  = ir & 32'h1F;
        int    rn  = (ir >> 5) & 32'h1F;
        int    rm  = (ir >> 16) & 32'h1F;
        int    imm = (ir >> 10) & 32'hFFF;
        int    d   = (ir >> 12) & 32'h1FF;
        int    br  = ir & 32'h3FFFFFF;
        int    cb  = (ir >> 5) & 32'h7FFFF;
        if (d >= 256) d -= 512;
        if (br >= 33554432) br -= 67108864;
        if (cb >= 262144) cb -= 524288;
        w = mk(3'd1, 8'h00, 1'b1, 2'd0, 2'b00, 5'd8, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        if (step == 0) begin
            w.state = 3'd0; w.en = 8'b0010_1000; w.dts = 2'd3; w.pc_fs = 2'b01;
        end else if (step >= 2) begin
            case (c)
                C_ADD, C_SUB, C_ADDI: begin
                    w.state = 3'd2; w.sa = 5'(rn); w.sb = 5'(rm); w.da = 5'(rd);
                    w.en[7] = 1'b1;
                    if (c == C_SUB) begin w.fs = 5'd9; w.en[6] = 1'b1; end
                    if (c == C_ADDI) begin w.en[1] = 1'b1; w.k = 32'(imm); end
                end
                C_LDUR: begin
                    w.state = 3'd3; w.sa = 5'(rn); w.k = 32'(d); w.add_tri = 1'b0;
                    w.en = 8'b1010_0010; w.dts = 2'd3; w.da = 5'(rd);
                end
                C_STUR: begin
                    w.state = 3'd3; w.sa = 5'(rn); w.k = 32'(d); w.add_tri = 1'b0;
                    w.en = 8'b0011_0010; w.dts = 2'd1; w.sb = 5'(rd);
                end
                C_B: begin
                    w.state = 3'd4; w.pc_fs = 2'b11; w.en = 8'b0000_0001; w.k = 32'(br * 4 - 4);
                end
                C_CBZ: begin
                    if (step == 2) begin
                        w.state = 3'd5; w.sa = 5'(rd); w.en = 8'b0000_0110;
                    end else begin
                        w.state = 3'd6;
                        if (z) begin
                            w.pc_fs = 2'b11; w.en = 8'b0000_0001; w.k = 32'(cb * 4 - 4);
                        end
                    end
                end
                default: begin
                    w.state = 3'd7; w.halted = 1'b1;
                end
            endcase
        end
        return w;
    endfunction

    // Asynchronous reset pulse issued mid-cycle; no clock edge occurs while it is high.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic add_vec(input string n, input logic [31:0] ir, input logic z,
                           input int step, input word_t exp);
        vec_t v;
        v.name = n; v.ir = ir; v.z = z; v.step = step; v.exp = exp;
        tv.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        word_t fetch_w;
        word_t inert_w;
        fetch_w = mk(3'd0, 8'b0010_1000, 1'b1, 2'd3, 2'b01, 5'd8, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        inert_w = mk(3'd1, 8'h00, 1'b1, 2'd0, 2'b00, 5'd8, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);

        add_vec("add_fetch",  32'h8B020023, 1'b0, 0, fetch_w);
        add_vec("add_decode", 32'h8B020023, 1'b0, 1, inert_w);
        add_vec("add_exec",   32'h8B020023, 1'b0, 2,
                mk(3'd2, 8'b1000_0000, 1'b1, 2'd0, 2'b00, 5'd8, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0));
        add_vec("add_back",   32'h8B020023, 1'b0, 3, fetch_w);
        add_vec("sub_exec",   32'hCB020023, 1'b0, 2,
                mk(3'd2, 8'b1100_0000, 1'b1, 2'd0, 2'b00, 5'd9, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0));
        add_vec("addi_exec",  32'h91002C41, 1'b0, 2,
                mk(3'd2, 8'b1000_0010, 1'b1, 2'd0, 2'b00, 5'd8, 5'd2, 5'd0, 5'd1, 32'd11, 1'b0));
        add_vec("ldur_mem",   32'hF8408045, 1'b0, 2,
                mk(3'd3, 8'b1010_0010, 1'b0, 2'd3, 2'b00, 5'd8, 5'd2, 5'd0, 5'd5, 32'd8, 1'b0));
        add_vec("ldur_negd",  32'hF85FF045, 1'b0, 2,
                mk(3'd3, 8'b1010_0010, 1'b0, 2'd3, 2'b00, 5'd8, 5'd2, 5'd0, 5'd5, 32'hFFFFFFFF, 1'b0));
        add_vec("stur_mem",   32'hF8008045, 1'b0, 2,
                mk(3'd3, 8'b0011_0010, 1'b0, 2'd1, 2'b00, 5'd8, 5'd2, 5'd5, 5'd0, 32'd8, 1'b0));
        add_vec("b_neg2",     32'h17FFFFFE, 1'b0, 2,
                mk(3'd4, 8'b0000_0001, 1'b1, 2'd0, 2'b11, 5'd8, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF4, 1'b0));
        add_vec("b_maxpos",   32'h15FFFFFF, 1'b0, 2,
                mk(3'd4, 8'b0000_0001, 1'b1, 2'd0, 2'b11, 5'd8, 5'd0, 5'd0, 5'd0, 32'h07FFFFF8, 1'b0));
        add_vec("b_zero",     32'h14000000, 1'b1, 2,
                mk(3'd4, 8'b0000_0001, 1'b1, 2'd0, 2'b11, 5'd8, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0));
        add_vec("b_back",     32'h17FFFFFE, 1'b0, 3, fetch_w);
        add_vec("cbz1_z1",    32'hB4000064, 1'b1, 2,
                mk(3'd5, 8'b0000_0110, 1'b1, 2'd0, 2'b00, 5'd8, 5'd4, 5'd0, 5'd0, 32'd0, 1'b0));
        add_vec("cbz2_z1",    32'hB4000064, 1'b1, 3,
                mk(3'd6, 8'b0000_0001, 1'b1, 2'd0, 2'b11, 5'd8, 5'd0, 5'd0, 5'd0, 32'd8, 1'b0));
        add_vec("cbz1_z0",    32'hB4000064, 1'b0, 2,
                mk(3'd5, 8'b0000_0110, 1'b1, 2'd0, 2'b00, 5'd8, 5'd4, 5'd0, 5'd0, 32'd0, 1'b0));
        add_vec("cbz2_z0",    32'hB4000064, 1'b0, 3,
                mk(3'd6, 8'h00, 1'b1, 2'd0, 2'b00, 5'd8, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0));
        add_vec("cbz_back",   32'hB4000064, 1'b0, 4, fetch_w);
        add_vec("cbz2_neg",   32'hB4FFFFE4, 1'b1, 3,
                mk(3'd6, 8'b0000_0001, 1'b1, 2'd0, 2'b11, 5'd8, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 1'b0));
        add_vec("halt_zero",  32'h00000000, 1'b0, 2,
                mk(3'd7, 8'h00, 1'b1, 2'd0, 2'b00, 5'd8, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1));
        add_vec("halt_ones",  32'hFFFFFFFF, 1'b1, 2,
                mk(3'd7, 8'h00, 1'b1, 2'd0, 2'b00, 5'd8, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1));

        reset = 1'b1;
        bus.IR_out = 32'h0;
        bus.status = 4'h0;
        repeat (2) @(posedge clock);
        #1;
        check_word("reset_hold", observe(), fetch_w);
        reset = 1'b0;

        // ---------------- directed vector table ----------------
        foreach (tv[i]) begin
            do_reset();
            bus.IR_out = tv[i].ir;
            bus.status = {3'b101, tv[i].z};
            for (int s = 0; s < tv[i].step; s++) tick();
            check_word(tv[i].name, observe(), tv[i].exp);
            $display("vec %-10s ir=%h z=%0d step=%0d", tv[i].name, tv[i].ir, tv[i].z, tv[i].step);
            tick();
        end

        // ---------------- halt persistence and restart ----------------
        do_reset();
        bus.IR_out = 32'h0;
        tick();
        tick();
        for (int c = 0; c < 10; c++) begin
            check_val("halt_state", {28'd0, bus.state, bus.halted}, {28'd0, 3'd7, 1'b1});
            check_val("halt_enables", {24'd0, observe().en}, 32'd0);
            tick();
        end
        do_reset();
        check_val("halt_exit_state", {29'd0, bus.state}, 32'd0);
        check_val("halt_exit_halted", {31'd0, bus.halted}, 32'd0);
        bus.IR_out = 32'h8B020023;
        for (int s = 1; s <= 3; s++) begin
            tick();
            check_val("restart_seq", {29'd0, bus.state}, (s == 3) ? 32'd0 : 32'(s));
        end
        $display("seq halt_then_restart");

        // ---------------- reset in the middle of a store ----------------
        do_reset();
        bus.IR_out = 32'hF8008045;
        tick();
        tick();
        check_val("stur_we_before", {31'd0, bus.mem_write_en}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("stur_we_async", {31'd0, bus.mem_write_en}, 32'd0);
        check_val("stur_state_async", {29'd0, bus.state}, 32'd0);
        check_val("stur_cs_async", {31'd0, bus.IR_load}, 32'd1);
        reset = 1'b0;
        tick();
        check_val("stur_after_reset", {29'd0, bus.state}, 32'd1);
        $display("seq stur_reset_mid_mem");

        // ---------------- random instruction stream ----------------
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ir;
            logic        z;
            logic [31:0] r;
            cls_t        c;
            int          len;
            r = $urandom;
            z = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: ir = {11'b10001011000, r[20:0]};
                1: ir = {11'b11001011000, r[20:0]};
                2: ir = {10'b1001000100,  r[21:0]};
                3: ir = {11'b11111000010, r[20:0]};
                4: ir = {11'b11111000000, r[20:0]};
                5: ir = {6'b000101,       r[25:0]};
                6: ir = {8'b10110100,     r[23:0]};
                default: ir = r;
            endcase
            c = classify(ir);
            len = instr_len(c);
            bus.IR_out = ir;
            bus.status = {r[31:29], z};
            if (len == 0) begin
                int hold = $urandom_range(3, 6);
                for (int s = 0; s < hold; s++) begin
                    check_word("rand_halt", observe(), model(ir, z, s));
                    tick();
                end
                do_reset();
            end else begin
                for (int s = 0; s < len; s++) begin
                    check_word("rand_instr", observe(), model(ir, z, s));
                    tick();
                end
            end
            $display("rand %0d ir=%h class=%0d z=%0d", n, ir, c, z);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
